// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduling path.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } tx_sched_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above ptr,
// wrapping to the lowest set request overall.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [N-1:0]  req_hi;
  logic          hit_hi;
  logic          hit_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  always_comb begin
    req_hi = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = 0; i < N; i++) begin
      req_hi[i] = req[i] && (IW'(i) >= ptr);
    end
    // Descending scan: the last hit written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        hit_hi = 1'b1;
        idx_hi = IW'(i);
      end
      if (req[i]) begin
        hit_lo = 1'b1;
        idx_lo = IW'(i);
      end
    end
    grant_idx = hit_hi ? idx_hi : idx_lo;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = advance && (hit_hi || hit_lo) && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx unit between N_REQ byte sources, one byte per grant,
// with per-byte timeout and an enforced idle gap between bytes.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 65535,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err
);

  localparam int IW  = $clog2(N_REQ);
  localparam int TB  = $clog2(TIMEOUT + 1);
  localparam int CW  = (TB < 16) ? 16 : TB;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  tx_sched_state_t state_q, state_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic              tx_send_q, tx_send_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CW-1:0]     tmo_q, tmo_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [IW-1:0]     arb_ptr;
  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_idx;
  logic [BYTE_W-1:0] arb_data;

  assign arb_ptr = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (arb_ptr),
    .advance   (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    arb_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) arb_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_d   = '0;
    tx_send_d     = tx_send_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    timeout_err_d = 1'b0;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    unique case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          state_d      = START;
          req_ready_d  = arb_grant;
          tx_send_d    = 1'b1;
          tx_data_d    = arb_data;
          grant_id_d   = arb_idx;
          last_grant_d = arb_idx;
          tmo_d        = '0;
        end
      end
      START, WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          state_d       = IDLE;
          tx_send_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else if (state_q == START) begin
          if (tx_active) begin
            state_d   = WAIT;
            tx_send_d = 1'b0;
          end
        end else if (!tx_active && tx_done) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= '0;
      tx_send_q     <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= LAST_IDX;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      tx_send_q     <= tx_send_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule
